char_out_tx: RTL

//  Memory-mapped character output port on the picorv32 native memory bus inside top.

---
 rtl/char_out_tx_pkg.sv | 29 ++
 rtl/char_out_tx_if.sv | 21 ++
 rtl/char_out_tx_sync_fifo.sv | 53 +++++
 rtl/char_out_tx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/char_out_tx_pkg.sv
// Shared definitions for the character output port: register offsets,
// STATUS bit layout, pacing FSM states and the STATUS word builder.
package char_out_tx_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_LEVEL_LSB = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } tx_state_e;

  // Assemble the STATUS read word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic [7:0] level);
    logic [31:0] v;
    v = 32'h0000_0000;
    v[STAT_FULL_BIT]                       = full;
    v[STAT_EMPTY_BIT]                      = empty;
    v[STAT_LEVEL_LSB +: 8]                 = level;
    return v;
  endfunction

endpackage

// File: rtl/char_out_tx_if.sv
// picorv32 native memory bus slice seen by the character output port,
// including the address decode select from the top level.
interface char_out_tx_if;
  logic        sel;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/char_out_tx_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers for full/empty detection.
// Push while full and pop while empty are dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [7:0]       o_level
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW:0]      w_level;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign o_level   = 8'(w_level);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are meaningless until pushed so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/char_out_tx.sv
// Memory-mapped character output port. Bytes written to DATA are queued
// and emitted on out_dat with one out_ctl toggle each, spaced at least
// GAP_CYCLES clocks apart so a negedge receiver can sample every byte.
module char_out_tx
  import char_out_tx_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  char_out_tx_if.slave  bus,
  output logic [7:0]    out_dat,
  output logic          out_ctl
);

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  logic        r_ready;
  logic [31:0] r_rdata;
  tx_state_e   r_state;
  logic [GW-1:0] r_gap;
  logic [7:0]  r_dat;
  logic        r_ctl;

  logic        w_accept, w_is_data, w_is_status, w_push_req, w_take, w_push;
  logic [31:0] w_rdata_nxt;
  tx_state_e   w_state_nxt;
  logic [GW-1:0] w_gap_nxt;
  logic [7:0]  w_dat_nxt;
  logic        w_ctl_nxt, w_pop;
  logic [7:0]  w_fifo_head, w_fifo_level;
  logic        w_fifo_full, w_fifo_empty;
  logic        w_unused_ok;

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign out_dat       = r_dat;
  assign out_ctl       = r_ctl;
  assign w_unused_ok   = ^bus.mem_wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (bus.mem_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  // Bus decode: a DATA push against a full FIFO (before any same-cycle pop) is held off.
  always_comb begin
    w_accept    = bus.sel & bus.mem_valid & ~r_ready;
    w_is_data   = (bus.mem_addr == ADDR_DATA);
    w_is_status = (bus.mem_addr == ADDR_STATUS);
    w_push_req  = w_is_data & bus.mem_wstrb[0];
    w_take      = w_accept & ~(w_push_req & w_fifo_full);
    w_push      = w_take & w_push_req;
    if (w_take && w_is_status && (bus.mem_wstrb == 4'b0000)) begin
      w_rdata_nxt = pack_status(w_fifo_full,
                                w_fifo_empty & (r_state == ST_IDLE),
                                w_fifo_level);
    end else begin
      w_rdata_nxt = 32'h0000_0000;
    end
  end

  // One-cycle acknowledge with read data captured alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_ready <= w_take;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Pacing FSM next state: launch a byte from IDLE, then hold for the gap.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_dat_nxt   = r_dat;
    w_ctl_nxt   = r_ctl;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_dat_nxt   = w_fifo_head;
          w_ctl_nxt   = ~r_ctl;
          w_pop       = 1'b1;
          w_gap_nxt   = GAP_LOAD;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Leaving on the final decrement lets the next launch land exactly GAP_CYCLES later.
        if (r_gap <= GAP_ONE) begin
          w_gap_nxt   = {GW{1'b0}};
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt   = r_gap - GAP_ONE;
        end
      end
      default: begin
        w_gap_nxt   = {GW{1'b0}};
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pacing FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gap   <= {GW{1'b0}};
      r_dat   <= 8'h00;
      r_ctl   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_dat   <= w_dat_nxt;
      r_ctl   <= w_ctl_nxt;
    end
  end

endmodule
